// File: rtl/flo_norm_seq.sv
// flo_norm_seq
// Iterative leading-one normalizer. A wide mantissa is accepted over a
// valid/ready handshake. It is scanned MSB-first, one CHUNK-bit slice per
// cycle, by a narrow leading-one detector. The word is then shifted left so
// that its MSB is 1. The shifted word and the shift count are returned over
// a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   high only while idle (state decode)
//   in_data    N-bit mantissa to normalize
//   out_valid  result valid; high only in DONE
//   out_ready  consumer accepts result
//   out_data   in_data << out_shift (registered)
//   out_shift  leading-zero count, 0..N (registered)
//   out_zero   input word was all zeros (registered)
//
// Optional build macro: FLO_NORM_SEQ_ZERO_DET_EN
//   When defined, a full-width OR-reduce of the input is registered at
//   acceptance. Zero words then skip the scan and complete in one edge.

module flo_norm_seq #(
    parameter int N     = 64,
    parameter int CHUNK = 16,
    parameter int E_W   = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic [E_W-1:0] out_shift,
    output logic           out_zero
);

    localparam int M  = N / CHUNK;
    localparam int KW = $clog2(M);
    localparam int CW = $clog2(CHUNK);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t         state, state_n;
    logic [N-1:0]   data, data_n;
    logic [KW-1:0]  k, k_n;
    logic [N-1:0]   od_n;
    logic [E_W-1:0] os_n;
    logic           oz_n, ov_n;

    logic [CHUNK-1:0] slice;
    logic [CW-1:0]    lz;
    logic [E_W-1:0]   kbase;
    logic             zero_fast;

`ifdef FLO_NORM_SEQ_ZERO_DET_EN
    logic nz, nz_n;
    assign zero_fast = ~nz;
`else
    assign zero_fast = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    // Current slice, MSB-first: slice k covers data[N-1-k*CHUNK -: CHUNK].
    assign slice = data[(N-1) - int'(k)*CHUNK -: CHUNK];

    // Bit offset of the slice start: k*CHUNK, formed by concatenation.
    assign kbase = E_W'({k, {CW{1'b0}}});

    // Narrow leading-one detector. The ascending loop lets the highest set
    // bit win, which gives the leading-zero count of the slice.
    always_comb begin
        lz = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (slice[i]) lz = CW'(CHUNK - 1 - i);
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        k_n     = k;
        od_n    = out_data;
        os_n    = out_shift;
        oz_n    = out_zero;
        ov_n    = out_valid;
`ifdef FLO_NORM_SEQ_ZERO_DET_EN
        nz_n    = nz;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_n  = in_data;
                    k_n     = '0;
                    oz_n    = 1'b0;
`ifdef FLO_NORM_SEQ_ZERO_DET_EN
                    nz_n    = |in_data;
`endif
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (zero_fast || (slice == '0 && k == KW'(M - 1))) begin
                    os_n    = E_W'(N);
                    oz_n    = 1'b1;
                    od_n    = '0;
                    ov_n    = 1'b1;
                    state_n = DONE;
                end else if (slice != '0) begin
                    // Maximum is N-1 for a nonzero word, so E_W bits suffice.
                    os_n    = kbase + E_W'(lz);
                    state_n = SHIFT;
                end else begin
                    k_n = k + KW'(1);
                end
            end
            SHIFT: begin
                od_n    = data << out_shift;
                ov_n    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data      <= '0;
            k         <= '0;
            out_data  <= '0;
            out_shift <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
`ifdef FLO_NORM_SEQ_ZERO_DET_EN
            nz        <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            data      <= data_n;
            k         <= k_n;
            out_data  <= od_n;
            out_shift <= os_n;
            out_zero  <= oz_n;
            out_valid <= ov_n;
`ifdef FLO_NORM_SEQ_ZERO_DET_EN
            nz        <= nz_n;
`endif
        end
    end

endmodule
